gfau: RTL and testbench

GFAU -- requirements
Module: gfau

---
 rtl/gfau_pkg.sv | 20 ++
 rtl/gfau_div_core.sv | 90 +++++++++
 rtl/gfau.sv | 167 ++++++++++++++++
 tb/tb_gfau.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/gfau_pkg.sv
// Shared constants for the GF(p) arithmetic unit: default width, opcodes, FSM encoding.
package gfau_pkg;

    localparam int SIZE_DEF = 32;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MULT = 2'd2;
    localparam logic [1:0] OP_DIV  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD  = 3'd1,
        ST_SUB  = 3'd2,
        ST_MULT = 3'd3,
        ST_DIV  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/gfau_div_core.sv
// Modular divider a * b^-1 mod p using binary extended Euclid, one reduction step per cycle.
// Only instantiated when GFAU_DIV_EN is defined.
module gfau_div_core #(
    parameter int SIZE = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [SIZE-1:0] a_i,
    input  logic [SIZE-1:0] b_i,
    input  logic [SIZE-1:0] p_i,
    output logic            done_o,
    output logic [SIZE-1:0] quotient_o
);

    localparam int CW = $clog2(2 * SIZE);
    localparam logic [SIZE-1:0] ONE = SIZE'(1);

    logic [SIZE-1:0] u_q, v_q, x1_q, x2_q, p_q;
    logic [SIZE-1:0] u_d, v_d, x1_d, x2_d;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;

    function automatic logic [SIZE-1:0] halve(input logic [SIZE-1:0] x, input logic [SIZE-1:0] m);
        logic [SIZE:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return SIZE'(s >> 1);
    endfunction

    function automatic logic [SIZE-1:0] sub_mod(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                                                 input logic [SIZE-1:0] m);
        return (x >= y) ? (x - y) : (x - y + m);
    endfunction

    // u==0 covers b==0 (quotient 0); cnt==0 bounds runs with out-of-range operands.
    assign done_o     = busy_q && ((u_q == ONE) || (v_q == ONE) || (u_q == '0) || (cnt_q == '0));
    assign quotient_o = (u_q == ONE) ? x1_q : ((v_q == ONE) ? x2_q : '0);

    // Both-odd branch halves the (even) difference in the same cycle.
    always_comb begin
        u_d  = u_q;
        v_d  = v_q;
        x1_d = x1_q;
        x2_d = x2_q;
        if (!u_q[0]) begin
            u_d  = u_q >> 1;
            x1_d = halve(x1_q, p_q);
        end else if (!v_q[0]) begin
            v_d  = v_q >> 1;
            x2_d = halve(x2_q, p_q);
        end else if (u_q >= v_q) begin
            u_d  = (u_q - v_q) >> 1;
            x1_d = halve(sub_mod(x1_q, x2_q, p_q), p_q);
        end else begin
            v_d  = (v_q - u_q) >> 1;
            x2_d = halve(sub_mod(x2_q, x1_q, p_q), p_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            u_q    <= '0;
            v_q    <= '0;
            x1_q   <= '0;
            x2_q   <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            u_q    <= b_i;
            v_q    <= p_i;
            x1_q   <= a_i;
            x2_q   <= '0;
            p_q    <= p_i;
            cnt_q  <= CW'(2 * SIZE - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (done_o) begin
                busy_q <= 1'b0;
            end else begin
                u_q   <= u_d;
                v_q   <= v_d;
                x1_q  <= x1_d;
                x2_q  <= x2_d;
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/gfau.sv
// GF(p) arithmetic unit: add/sub/mult (serial MSB-first) with optional divider.
// Define GFAU_DIV_EN to build the inverter; otherwise opcode 3 returns 0 after one cycle.
//
// state | meaning
// IDLE  | wait for done_from_control, capture operands and opcode
// ADD   | one-cycle modular add
// SUB   | one-cycle modular subtract
// MULT  | SIZE cycles of shift-add, one multiplier bit per cycle
// DIV   | wait for divider core (or one cycle when divider is not built)
// DONE  | one-cycle completion pulse, result already registered
module gfau
    import gfau_pkg::*;
#(
    parameter int SIZE = SIZE_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [SIZE-1:0] in_0,
    input  logic [SIZE-1:0] in_1,
    input  logic [SIZE-1:0] prime,
    input  logic [1:0]      operation_select,
    input  logic            done_from_control,
    output logic [SIZE-1:0] result,
    output logic            done_to_control,
    output logic            done_add,
    output logic            done_sub,
    output logic            done_mult,
    output logic            done_div,
    output logic [2:0]      state
);

    localparam int AW = SIZE + 2;
    localparam int MW = $clog2(SIZE);

    state_t          state_q, state_d;
    logic [SIZE-1:0] a_q, b_q, p_q;
    logic [1:0]      op_q;
    logic [SIZE-1:0] result_q, result_d;
    logic [SIZE-1:0] acc_q, acc_d;
    logic [MW-1:0]   mcnt_q, mcnt_d;
    logic            capture;

    logic [SIZE:0]   sum_w;
    logic [SIZE-1:0] add_res, sub_res, mstep;
    logic [AW-1:0]   pw, dbl, dbl_r, madd;

    assign capture = (state_q == ST_IDLE) && done_from_control;

    assign sum_w   = {1'b0, a_q} + {1'b0, b_q};
    assign add_res = (sum_w >= {1'b0, p_q}) ? SIZE'(sum_w - {1'b0, p_q}) : sum_w[SIZE-1:0];
    assign sub_res = (a_q < b_q) ? (a_q - b_q + p_q) : (a_q - b_q);

    // acc stays < p: double, reduce, add a, reduce.
    assign pw    = {2'b00, p_q};
    assign dbl   = {1'b0, acc_q, 1'b0};
    assign dbl_r = (dbl >= pw) ? (dbl - pw) : dbl;
    assign madd  = dbl_r + (b_q[mcnt_q] ? {2'b00, a_q} : '0);
    assign mstep = (madd >= pw) ? SIZE'(madd - pw) : SIZE'(madd);

`ifdef GFAU_DIV_EN
    logic            div_start;
    logic            div_done;
    logic [SIZE-1:0] div_quot;

    gfau_div_core #(.SIZE(SIZE)) u_div (
        .clk_i      (i_clk),
        .rst_ni     (i_rst),
        .start_i    (div_start),
        .a_i        (in_0),
        .b_i        (in_1),
        .p_i        (prime),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        acc_d    = acc_q;
        mcnt_d   = mcnt_q;
`ifdef GFAU_DIV_EN
        div_start = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (done_from_control) begin
                    acc_d  = '0;
                    mcnt_d = MW'(SIZE - 1);
                    case (operation_select)
                        OP_ADD:  state_d = ST_ADD;
                        OP_SUB:  state_d = ST_SUB;
                        OP_MULT: state_d = ST_MULT;
                        OP_DIV: begin
                            state_d = ST_DIV;
`ifdef GFAU_DIV_EN
                            div_start = 1'b1;
`endif
                        end
                    endcase
                end
            end
            ST_ADD: begin
                result_d = add_res;
                state_d  = ST_DONE;
            end
            ST_SUB: begin
                result_d = sub_res;
                state_d  = ST_DONE;
            end
            ST_MULT: begin
                acc_d  = mstep;
                mcnt_d = mcnt_q - 1'b1;
                if (mcnt_q == '0) begin
                    result_d = mstep;
                    state_d  = ST_DONE;
                end
            end
            ST_DIV: begin
`ifdef GFAU_DIV_EN
                if (div_done) begin
                    result_d = div_quot;
                    state_d  = ST_DONE;
                end
`else
                result_d = '0;
                state_d  = ST_DONE;
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            acc_q    <= '0;
            mcnt_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            mcnt_q   <= mcnt_d;
            if (capture) begin
                a_q  <= in_0;
                b_q  <= in_1;
                p_q  <= prime;
                op_q <= operation_select;
            end
        end
    end

    assign result          = result_q;
    assign state           = state_q;
    assign done_to_control = (state_q == ST_DONE);
    assign done_add        = (state_q == ST_DONE) && (op_q == OP_ADD);
    assign done_sub        = (state_q == ST_DONE) && (op_q == OP_SUB);
    assign done_mult       = (state_q == ST_DONE) && (op_q == OP_MULT);
    assign done_div        = (state_q == ST_DONE) && (op_q == OP_DIV);

endmodule

// File: tb/tb_gfau.sv
// Directed bench for gfau: vector table of single operations plus reset/back-to-back sequences.
module tb_gfau;

    localparam int SIZE = 32;
`ifdef GFAU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [SIZE-1:0] in_0, in_1, prime;
    logic [1:0]      operation_select;
    logic            done_from_control;
    logic [SIZE-1:0] result;
    logic            done_to_control, done_add, done_sub, done_mult, done_div;
    logic [2:0]      state;

    int checks = 0;
    int errors = 0;

    gfau #(.SIZE(SIZE)) dut (
        .i_clk             (clk),
        .i_rst             (rst_n),
        .in_0              (in_0),
        .in_1              (in_1),
        .prime             (prime),
        .operation_select  (operation_select),
        .done_from_control (done_from_control),
        .result            (result),
        .done_to_control   (done_to_control),
        .done_add          (done_add),
        .done_sub          (done_sub),
        .done_mult         (done_mult),
        .done_div          (done_div),
        .state             (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        logic [SIZE-1:0] p;
        logic [1:0]      op;
        logic [SIZE-1:0] exp;
        int              cyc;   // exact cycles in op state; 0 = only bounded by 2*SIZE
        string           name;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v);
        int         n;
        logic [2:0] ost;
        logic [3:0] flags;
        ost = 3'(v.op) + 3'd1;
        @(negedge clk);
        in_0 = v.a; in_1 = v.b; prime = v.p; operation_select = v.op;
        done_from_control = 1'b1;
        @(negedge clk);
        done_from_control = 1'b0;
        in_0 = $urandom; in_1 = $urandom; operation_select = ~v.op;
        chk({v.name, "_enter"}, SIZE'(state), SIZE'(ost));
        n = 0;
        while (state == ost && n <= 2 * SIZE + 2) begin
            n++;
            @(negedge clk);
        end
        chk({v.name, "_reach_done"}, SIZE'(state), SIZE'(5));
        chk({v.name, "_result"}, result, v.exp);
        if (v.cyc != 0) begin
            chk({v.name, "_cycles"}, SIZE'(n), SIZE'(v.cyc));
        end else begin
            checks++;
            if (n < 1 || n > 2 * SIZE) begin
                errors++;
                $display("FAIL %s_cycles actual=%0d required=1..%0d", v.name, n, 2 * SIZE);
            end
        end
        flags = {done_div, done_mult, done_sub, done_add};
        chk({v.name, "_done_ctl"}, SIZE'(done_to_control), SIZE'(1));
        chk({v.name, "_done_flags"}, SIZE'(flags), SIZE'(4'b0001 << v.op));
        @(negedge clk);
        flags = {done_div, done_mult, done_sub, done_add};
        chk({v.name, "_back_idle"}, SIZE'(state), SIZE'(0));
        chk({v.name, "_flags_clear"}, SIZE'({flags, done_to_control}), SIZE'(0));
        chk({v.name, "_hold"}, result, v.exp);
    endtask

    initial begin
        int pulses, addp;
        vecs[0]  = '{86, 53, 97, 2'd0, 42, 1, "add_basic"};
        vecs[1]  = '{86, 53, 97, 2'd1, 33, 1, "sub_basic"};
        vecs[2]  = '{86, 53, 97, 2'd2, 96, SIZE, "mult_basic"};
        vecs[3]  = '{86, 53, 97, 2'd3, DIV_EN ? 32'd73 : 32'd0, DIV_EN ? 0 : 1, "div_basic"};
        vecs[4]  = '{86, 0, 97, 2'd3, 0, 1, "div_by_zero"};
        vecs[5]  = '{96, 96, 97, 2'd0, 95, 1, "add_wrap"};
        vecs[6]  = '{0, 1, 97, 2'd1, 96, 1, "sub_borrow"};
        vecs[7]  = '{96, 96, 97, 2'd2, 1, SIZE, "mult_max"};
        vecs[8]  = '{1, 96, 97, 2'd3, DIV_EN ? 32'd96 : 32'd0, DIV_EN ? 0 : 1, "div_inv"};
        vecs[9]  = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 2'd0, 32'hFFFF_FFF9, 1, "add_carry"};
        vecs[10] = '{32'h8000_0000, 2, 32'hFFFF_FFFB, 2'd2, 5, SIZE, "mult_wide"};
        vecs[11] = '{5, 7, 11, 2'd2, 2, SIZE, "mult_small"};
        vecs[12] = '{3, 2, 11, 2'd3, DIV_EN ? 32'd7 : 32'd0, DIV_EN ? 0 : 1, "div_small"};

        rst_n = 1'b0; in_0 = '0; in_1 = '0; prime = 32'd97;
        operation_select = 2'd0; done_from_control = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", SIZE'(state), SIZE'(0));
        chk("reset_result", result, SIZE'(0));
        chk("reset_done", SIZE'({done_to_control, done_add, done_sub, done_mult, done_div}), SIZE'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", SIZE'(state), SIZE'(0));

        for (int i = 0; i < 13; i++) do_op(vecs[i]);

        // Reset in the middle of a multiply: abandoned, no pulse, result cleared.
        @(negedge clk);
        in_0 = 86; in_1 = 53; prime = 97; operation_select = 2'd2; done_from_control = 1'b1;
        @(negedge clk);
        done_from_control = 1'b0;
        repeat (5) @(negedge clk);
        chk("mult_running", SIZE'(state), SIZE'(3));
        rst_n = 1'b0;
        #1;
        chk("midrst_state", SIZE'(state), SIZE'(0));
        chk("midrst_result", result, SIZE'(0));
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_to_control || done_mult) pulses++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_to_control || done_mult) pulses++;
        end
        chk("midrst_no_pulse", SIZE'(pulses), SIZE'(0));
        chk("midrst_stay_idle", SIZE'(state), SIZE'(0));

        // Start held high: ADD, DONE, IDLE repeats every three cycles.
        in_0 = 86; in_1 = 53; prime = 97; operation_select = 2'd0; done_from_control = 1'b1;
        pulses = 0; addp = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_to_control) pulses++;
            if (done_add) addp++;
        end
        done_from_control = 1'b0;
        chk("b2b_pulses", SIZE'(pulses), SIZE'(4));
        chk("b2b_add_pulses", SIZE'(addp), SIZE'(4));
        chk("b2b_result", result, SIZE'(42));
        repeat (3) @(negedge clk);
        chk("b2b_idle", SIZE'(state), SIZE'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
